// File: rtl/multicycle_ctrl_if.sv
// Control-to-datapath/memory bundle for the multi-cycle RV32I controller.
// A memory request completes on the cycle mem_req and mem_ready are both high; mem_req stays high until then.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        pc_write;
  logic        pc_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [2:0]  imm_type;
  logic [24:0] imm_in;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  modport master (
    input  instr, mem_ready, branch_taken,
    output mem_req, mem_we, ir_write, pc_write, pc_sel, reg_we, wb_sel,
           alu_a_sel, alu_b_sel, imm_type, imm_in, illegal, state, instret
  );

  modport slave (
    output instr, mem_ready, branch_taken,
    input  mem_req, mem_we, ir_write, pc_write, pc_sel, reg_we, wb_sel,
           alu_a_sel, alu_b_sel, imm_type, imm_in, illegal, state, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, imm32
// configuration, datapath strobes and a retired-instruction counter.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_COUNT = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [24:0] imm_in_q, imm_in_d;
  logic [2:0]  imm_type_q, imm_type_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instret_q, instret_d;

  logic [2:0]  dec_imm_type;
  logic        dec_legal;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_op, is_auipc;

  logic        mem_req, mem_we, ir_write, pc_write, pc_sel, reg_we;
  logic [1:0]  wb_sel;
  logic        alu_a_sel, alu_b_sel;

  // Classification of the raw IR word, only consumed in DECODE
  always_comb begin
    dec_imm_type = 3'd0;
    dec_legal    = 1'b1;
    unique case (bus.instr[6:0])
      OPC_OP_IMM: dec_imm_type = (bus.instr[14:12] == 3'b001 ||
                                  bus.instr[14:12] == 3'b101) ? 3'd5 : 3'd0;
      OPC_LOAD, OPC_JALR, OPC_OP: dec_imm_type = 3'd0;
      OPC_STORE:                  dec_imm_type = 3'd2;
      OPC_BRANCH:                 dec_imm_type = 3'd1;
      OPC_LUI, OPC_AUIPC:         dec_imm_type = 3'd3;
      OPC_JAL:                    dec_imm_type = 3'd4;
      default:                    dec_legal    = 1'b0;
    endcase
  end

  assign is_load   = (opcode_q == OPC_LOAD);
  assign is_store  = (opcode_q == OPC_STORE);
  assign is_branch = (opcode_q == OPC_BRANCH);
  assign is_jal    = (opcode_q == OPC_JAL);
  assign is_jalr   = (opcode_q == OPC_JALR);
  assign is_op     = (opcode_q == OPC_OP);
  assign is_auipc  = (opcode_q == OPC_AUIPC);

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    imm_in_d   = imm_in_q;
    imm_type_d = imm_type_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = 2'd0;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        opcode_d   = bus.instr[6:0];
        imm_in_d   = bus.instr[31:7];
        imm_type_d = dec_imm_type;
        state_d    = dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_b_sel = !(is_op || is_branch);
        alu_a_sel = is_auipc || is_jal || is_branch;
        if (is_branch) begin
          pc_write = 1'b1;
          pc_sel   = bus.branch_taken;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (bus.mem_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        pc_write = 1'b1;
        wb_sel   = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        pc_sel   = is_jal || is_jalr;
        state_d  = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Every entry into FETCH other than from reset is a retirement
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      opcode_q   <= 7'd0;
      imm_in_q   <= 25'd0;
      imm_type_q <= 3'd0;
      illegal_q  <= 1'b0;
      instret_q  <= RESET_COUNT;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      imm_in_q   <= imm_in_d;
      imm_type_q <= imm_type_d;
      illegal_q  <= illegal_d;
      instret_q  <= instret_d;
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.ir_write  = ir_write;
  assign bus.pc_write  = pc_write;
  assign bus.pc_sel    = pc_sel;
  assign bus.reg_we    = reg_we;
  assign bus.wb_sel    = wb_sel;
  assign bus.alu_a_sel = alu_a_sel;
  assign bus.alu_b_sel = alu_b_sel;
  assign bus.imm_type  = imm_type_q;
  assign bus.imm_in    = imm_in_q;
  assign bus.illegal   = illegal_q;
  assign bus.state     = state_q;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each directed
// instruction into its expected per-cycle outputs, checked every cycle.
module tb_multicycle_ctrl;
  localparam logic [31:0] RC = 32'd0;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5;

  localparam logic [31:0] I_ADDI  = 32'hFFC98993;
  localparam logic [31:0] I_BEQ   = 32'h02540063;
  localparam logic [31:0] I_SW    = 32'h0079A023;
  localparam logic [31:0] I_LW    = 32'h0009A503;
  localparam logic [31:0] I_AUIPC = 32'h00000517;
  localparam logic [31:0] I_JAL   = 32'h0200006F;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_SLLI  = 32'h00199993;
  localparam logic [31:0] I_SRAI  = 32'h4019D993;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_ADD   = 32'h00B50533;
  localparam logic [31:0] I_BAD   = 32'h00000000;

  typedef struct packed {
    logic [2:0]  state;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic        pc_sel;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [2:0]  imm_type;
    logic [24:0] imm_in;
    logic        illegal;
    logic [31:0] instret;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl #(.RESET_COUNT(RC)) dut (.clk(clk), .rst(rst), .bus(bus));

  // scoreboard
  obs_t        exp_q[$];
  logic [47:0] tag_q[$];
  bit          known_q[$];
  logic [47:0] pin_tag_q[$];
  logic [31:0] pin_got_q[$];
  logic [31:0] pin_exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // instruction-level model state
  logic [31:0] m_instret;
  logic [2:0]  m_imm_type;
  logic [24:0] m_imm_in;
  logic        m_illegal;
  bit          m_imm_known;

  obs_t ck_e, ck_a;
  logic [47:0] ck_t;
  bit ck_k;
  logic [31:0] ck_g, ck_w;

  always @(negedge clk) begin
    cyc_no++;
    if (exp_q.size() != 0) begin
      ck_e = exp_q.pop_front();
      ck_t = tag_q.pop_front();
      ck_k = known_q.pop_front();
      ck_a = '{bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write,
               bus.pc_sel, bus.reg_we, bus.wb_sel, bus.alu_a_sel, bus.alu_b_sel,
               bus.imm_type, bus.imm_in, bus.illegal, bus.instret};
      if (!ck_k) ck_a.imm_type = ck_e.imm_type;
      n_tests++;
      if (ck_a !== ck_e) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", ck_t, cyc_no, ck_a, ck_e);
      end
    end
    while (pin_got_q.size() != 0) begin
      ck_t = pin_tag_q.pop_front();
      ck_g = pin_got_q.pop_front();
      ck_w = pin_exp_q.pop_front();
      n_tests++;
      if (ck_g !== ck_w) begin
        n_fail++;
        $display("FAIL %s got=%h exp=%h", ck_t, ck_g, ck_w);
      end
    end
  end

  task automatic pin(input logic [47:0] tag, input logic [31:0] got, input logic [31:0] want);
    pin_tag_q.push_back(tag);
    pin_got_q.push_back(got);
    pin_exp_q.push_back(want);
  endtask

  function automatic obs_t blank(input logic [2:0] st);
    obs_t e;
    e          = '0;
    e.state    = st;
    e.imm_type = m_imm_type;
    e.imm_in   = m_imm_in;
    e.illegal  = m_illegal;
    e.instret  = m_instret;
    return e;
  endfunction

  task automatic model_reset();
    m_instret   = RC;
    m_imm_type  = 3'd0;
    m_imm_in    = 25'd0;
    m_illegal   = 1'b0;
    m_imm_known = 1'b1;
  endtask

  // Drive one cycle's inputs, queue its expectation, advance to posedge+1
  task automatic step(input logic r, input logic mr, input logic bt, input obs_t e,
                      input logic [47:0] tag, input bit known);
    rst              = r;
    bus.mem_ready    = mr;
    bus.branch_taken = bt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    known_q.push_back(known);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input int n);
    obs_t e;
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 1; i < n; i++) begin
      e = blank(ST_FETCH);
      e.mem_req = 1'b1; e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1;
      step(1'b1, 1'b0, 1'b0, e, "reset", 1'b1);
    end
  endtask

  // Expand one instruction into its expected cycles; fw/mw = wait cycles in FETCH/MEM
  task automatic run(input logic [31:0] ins, input int fw, input int mw, input logic taken,
                     input bit rst_in_mem, output int ncyc);
    logic [6:0] oc;
    logic [2:0] f3, it;
    bit legal, ld, st, br, jal, jalr, op, aui;
    logic rdy;
    obs_t e;
    oc = ins[6:0]; f3 = ins[14:12];
    legal = 1; it = 3'd0;
    ld = 0; st = 0; br = 0; jal = 0; jalr = 0; op = 0; aui = 0;
    case (oc)
      7'b0010011: it = (f3 == 3'b001 || f3 == 3'b101) ? 3'd5 : 3'd0;
      7'b0000011: ld = 1;
      7'b1100111: jalr = 1;
      7'b0100011: begin st = 1; it = 3'd2; end
      7'b1100011: begin br = 1; it = 3'd1; end
      7'b0110111: it = 3'd3;
      7'b0010111: begin aui = 1; it = 3'd3; end
      7'b1101111: begin jal = 1; it = 3'd4; end
      7'b0110011: op = 1;
      default:    legal = 0;
    endcase
    bus.instr = ins;
    ncyc = 0;
    for (int i = 0; i <= fw; i++) begin
      e = blank(ST_FETCH);
      e.mem_req = 1'b1; e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1;
      e.ir_write = (i == fw);
      step(1'b0, e.ir_write, rnd(), e, "fetch", m_imm_known);
      ncyc++;
    end
    e = blank(ST_DECODE);
    step(1'b0, rnd(), rnd(), e, "decode", m_imm_known);
    ncyc++;
    m_imm_in = ins[31:7];
    m_imm_type = it;
    m_imm_known = legal;
    if (!legal) begin
      m_illegal = 1'b1;
      return;
    end
    e = blank(ST_EXEC);
    e.alu_b_sel = !(op || br);
    e.alu_a_sel = aui || jal || br;
    if (br) begin
      e.pc_write = 1'b1;
      e.pc_sel   = taken;
      step(1'b0, rnd(), taken, e, "exec", 1'b1);
      ncyc++;
      m_instret++;
      return;
    end
    step(1'b0, rnd(), rnd(), e, "exec", 1'b1);
    ncyc++;
    if (ld || st) begin
      for (int j = 0; j <= mw; j++) begin
        e = blank(ST_MEM);
        e.mem_req = 1'b1;
        e.mem_we  = st;
        if (rst_in_mem) begin
          step(1'b1, 1'b0, rnd(), e, "mem", 1'b1);
          ncyc++;
          model_reset();
          return;
        end
        rdy = (j == mw);
        e.pc_write = st && rdy;
        step(1'b0, rdy, rnd(), e, "mem", 1'b1);
        ncyc++;
      end
      if (st) begin
        m_instret++;
        return;
      end
    end
    e = blank(ST_WB);
    e.reg_we   = 1'b1;
    e.pc_write = 1'b1;
    e.wb_sel   = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
    e.pc_sel   = jal || jalr;
    step(1'b0, rnd(), rnd(), e, "wb", 1'b1);
    ncyc++;
    m_instret++;
  endtask

  task automatic trap_cycles(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = blank(ST_TRAP);
      step(1'b0, rnd(), rnd(), e, "trap", m_imm_known);
    end
  endtask

  initial begin
    int n;
    bus.instr = 32'd0;
    do_reset(2);

    run(I_ADDI, 0, 0, 1'b0, 1'b0, n);
    pin("addlat", 32'(n), 32'd4);
    pin("addimm", 32'(bus.imm_in), 32'h01FF9313);
    pin("mdlimm", 32'(m_imm_in), 32'h01FF9313);
    pin("addity", 32'(bus.imm_type), 32'd0);
    pin("iret1", bus.instret, RC + 32'd1);

    run(I_BEQ, 0, 0, 1'b1, 1'b0, n);
    pin("beqlt1", 32'(n), 32'd3);
    pin("beqity", 32'(bus.imm_type), 32'd1);
    run(I_BEQ, 0, 0, 1'b0, 1'b0, n);
    pin("beqlt0", 32'(n), 32'd3);

    run(I_SW, 0, 3, 1'b0, 1'b0, n);
    pin("swlat", 32'(n), 32'd7);
    pin("swity", 32'(bus.imm_type), 32'd2);

    run(I_LW, 0, 0, 1'b0, 1'b0, n);
    pin("lwlat", 32'(n), 32'd5);
    run(I_AUIPC, 0, 0, 1'b0, 1'b0, n);
    pin("auilat", 32'(n), 32'd4);
    pin("auiity", 32'(bus.imm_type), 32'd3);
    run(I_JAL, 0, 0, 1'b0, 1'b0, n);
    pin("jallat", 32'(n), 32'd4);
    pin("jality", 32'(bus.imm_type), 32'd4);
    pin("iret7", bus.instret, RC + 32'd7);

    run(I_LUI, 2, 0, 1'b0, 1'b0, n);
    pin("luilat", 32'(n), 32'd6);
    run(I_SLLI, 0, 0, 1'b0, 1'b0, n);
    pin("slliit", 32'(bus.imm_type), 32'd5);
    run(I_SRAI, 1, 0, 1'b0, 1'b0, n);
    run(I_ADD, 0, 0, 1'b0, 1'b0, n);
    run(I_JALR, 0, 0, 1'b0, 1'b0, n);
    pin("jrlat", 32'(n), 32'd4);
    run(I_LW, 1, 2, 1'b0, 1'b0, n);
    pin("lwwlat", 32'(n), 32'd8);

    run(I_BAD, 0, 0, 1'b0, 1'b0, n);
    trap_cycles(10);
    pin("illeg", 32'(bus.illegal), 32'd1);
    pin("trapst", 32'(bus.state), 32'd5);
    do_reset(2);
    pin("illclr", 32'(bus.illegal), 32'd0);
    pin("rstst", 32'(bus.state), 32'd0);

    run(I_ADDI, 0, 0, 1'b0, 1'b0, n);
    run(I_LW, 0, 2, 1'b0, 1'b1, n);
    pin("rstcnt", bus.instret, RC);
    pin("rstreq", 32'(bus.mem_req), 32'd1);
    run(I_ADD, 0, 0, 1'b0, 1'b0, n);
    pin("iretfn", bus.instret, RC + 32'd1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
